// File: rtl/codes_pkg.sv
// Shared opcode, size and state codes for the execute and memory stages,
// plus small decode helpers used by the load/store stage.
package codes;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLT,
        OP_SLL,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_SB,
        OP_SH,
        OP_SW
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    function automatic logic is_mem_op(opcode_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_load(opcode_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_signed_load(opcode_t op);
        return op inside {OP_LB, OP_LH};
    endfunction

    // Access width; non-memory opcodes report word size and are never used.
    function automatic size_t op_size(opcode_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(opcode_t op, logic [1:0] offset);
        case (op_size(op))
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by loads and stores: byteenable generation,
// store-data replication, and load lane extraction with sign/zero extension.
module mem_lane_align
    import codes::*;
(
    input  opcode_t     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] read_data_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] write_data_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the read word.
    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = read_data_i[7:0];
            2'd1:    byte_sel = read_data_i[15:8];
            2'd2:    byte_sel = read_data_i[23:16];
            default: byte_sel = read_data_i[31:24];
        endcase
        half_sel = offset_i[1] ? read_data_i[31:16] : read_data_i[15:0];
    end

    // Lane masks, replicated store data and extended load data by access size.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        byteenable_o = 4'b1111;
        write_data_o = store_data_i;
        load_data_o  = read_data_i;
        case (op_size(op_i))
            SZ_BYTE: begin
                byteenable_o = 4'b0001 << offset_i;
                write_data_o = {4{store_data_i[7:0]}};
                load_data_o  = is_signed_load(op_i) ? {{24{byte_sel[7]}}, byte_sel}
                                                    : {24'b0, byte_sel};
            end
            SZ_HALF: begin
                byteenable_o = offset_i[1] ? 4'b1100 : 4'b0011;
                write_data_o = {2{store_data_i[15:0]}};
                load_data_o  = is_signed_load(op_i) ? {{16{half_sel[15]}}, half_sel}
                                                    : {16'b0, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: turns one ALU memory request into a single Avalon-MM word
// access with byte lanes, and returns the extended load result.
module mem_access
    import codes::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  opcode_t           opcode_i,
    input  logic [ADDR_W-1:0] effective_address_i,
    input  logic [31:0]       store_data_i,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_writedata_o,
    output logic [3:0]        mem_byteenable_o,
    input  logic              mem_waitrequest_i,
    input  logic [31:0]       mem_readdata_i,
    output logic [31:0]       load_data_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              addr_error_o
);

    mem_state_t        state_q, state_d;
    opcode_t           op_q, op_d;
    logic [1:0]        offset_q, offset_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_writedata_q, mem_writedata_d;
    logic [3:0]        mem_byteenable_q, mem_byteenable_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              addr_error_q, addr_error_d;

    opcode_t     align_op;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        misaligned;

    // The aligner sees the incoming request while idle and the latched one afterwards.
    always_comb begin
        align_op     = (state_q == IDLE) ? opcode_i : op_q;
        align_offset = (state_q == IDLE) ? effective_address_i[1:0] : offset_q;
        misaligned   = is_misaligned(opcode_i, effective_address_i[1:0]);
    end

    mem_lane_align u_lane_align (
        .op_i         (align_op),
        .offset_i     (align_offset),
        .store_data_i (store_data_i),
        .read_data_i  (mem_readdata_i),
        .byteenable_o (align_be),
        .write_data_o (align_wdata),
        .load_data_o  (align_load)
    );

    // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        offset_d         = offset_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        load_data_d      = load_data_q;
        addr_error_d     = addr_error_q;
        done_d           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && is_mem_op(opcode_i)) begin
                    op_d         = opcode_i;
                    offset_d     = effective_address_i[1:0];
                    load_data_d  = '0;
                    addr_error_d = misaligned;
                    if (misaligned) begin
                        // No bus cycle; report the error straight away.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d          = ACCESS;
                        mem_address_d    = {effective_address_i[ADDR_W-1:2], 2'b00};
                        mem_read_d       = is_load(opcode_i);
                        mem_write_d      = !is_load(opcode_i);
                        mem_byteenable_d = align_be;
                        mem_writedata_d  = align_wdata;
                    end
                end
            end
            ACCESS: begin
                // Bus signals are held unchanged until the slave drops waitrequest.
                if (!mem_waitrequest_i) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    done_d      = 1'b1;
                    if (is_load(op_q)) begin
                        load_data_d = align_load;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            op_q             <= OP_NOP;
            offset_q         <= 2'b00;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            load_data_q      <= '0;
            done_q           <= 1'b0;
            addr_error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q          <= state_d;
            op_q             <= op_d;
            offset_q         <= offset_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            load_data_q      <= load_data_d;
            done_q           <= done_d;
            addr_error_q     <= addr_error_d;
        end
    end

    assign mem_address_o    = mem_address_q;
    assign mem_read_o       = mem_read_q;
    assign mem_write_o      = mem_write_q;
    assign mem_writedata_o  = mem_writedata_q;
    assign mem_byteenable_o = mem_byteenable_q;
    assign load_data_o      = load_data_q;
    assign done_o           = done_q;
    assign addr_error_o     = addr_error_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: doc/mem_access.md
# mem_access

Load/store stage directly downstream of the ALU. Takes the ALU's effective address, store operand and opcode, and performs one Avalon-MM style word access with correct byte lanes. For loads it returns the extended result for register writeback; for stores it drives the masked write. Sub-word lane placement and extension for loads and stores are resolved here, not in the ALU.

## Interface

Parameters:
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: request strobe; sampled only in IDLE.
- `opcode_i`, in, `opcode_t`: one of `OP_LB`, `OP_LBU`, `OP_LH`, `OP_LHU`, `OP_LW`, `OP_SB`, `OP_SH`, `OP_SW`.
- `effective_address_i`, in, 32: byte address from the ALU.
- `store_data_i`, in, 32: raw rt value. Byte or halfword in the low bits.
- `mem_address_o`, out, 32: word-aligned address, bits [1:0] = 0.
- `mem_read_o`, out, 1: read request.
- `mem_write_o`, out, 1: write request.
- `mem_writedata_o`, out, 32: lane-placed store data.
- `mem_byteenable_o`, out, 4: active lanes.
- `mem_waitrequest_i`, in, 1: slave stall.
- `mem_readdata_i`, in, 32: read data. Valid in the cycle where read is high and waitrequest is low.
- `load_data_o`, out, 32: extended load result.
- `done_o`, out, 1: one-cycle completion pulse.
- `busy_o`, out, 1: high in every state except IDLE.
- `addr_error_o`, out, 1: misaligned access. Valid with `done_o`.

## Operation

- Byte ordering: the byte at address offset k (0..3) occupies lanes [8k+7:8k], and `byteenable[k]` covers it.
- States are IDLE, ACCESS and DONE.
- IDLE: when `start_i` is high and the opcode is a memory opcode, latch the opcode, address and store data.
  - Aligned request: next state is ACCESS.
  - Misaligned request (halfword with addr[0]=1, or word with addr[1:0]≠0): next state is DONE with `addr_error_o`=1 and no bus cycle.
  - Non-memory opcode: ignored; stay in IDLE.
- ACCESS: hold `mem_read_o` or `mem_write_o`, address, writedata and byteenable stable while `mem_waitrequest_i`=1.
  - In the first cycle with waitrequest=0, the transfer completes.
  - For loads, capture the lane-selected, extended data on that cycle.
  - Next state is DONE.
- DONE: `done_o`=1 for exactly one cycle, then return to IDLE.
  - `load_data_o` and `addr_error_o` hold their values until the next request is accepted.
- Byteenable: SB gives `1<<addr[1:0]`. SH gives 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1). SW gives 4'b1111. Loads use the same masks.
- Store data placement: SB replicates `store_data_i[7:0]` into all four lanes. SH replicates `[15:0]` into both halves. SW passes the word through.
- Load extension:
  - LB / LH sign-extend the selected lane.
  - LBU / LHU zero-extend.
  - LW passes the word through.
- `start_i` while busy is ignored; there is no queueing.
- Reset: asynchronous, with every output taking its reset value immediately.
  - An in-flight access is abandoned and is not retried.
  - Reset values: state = IDLE; all outputs 0, including `mem_read_o`, `mem_write_o`, `done_o`, `busy_o`, `addr_error_o`, `load_data_o`, `mem_address_o`, `mem_writedata_o` and `mem_byteenable_o`.

## Timing

- All bus outputs are registered; none depend combinationally on `start_i` or `mem_waitrequest_i`.
- Start is accepted in cycle 0.
- Read/write go high in cycle 1.
- With zero wait states, waitrequest=0 in cycle 1 and `done_o` pulses in cycle 2. Minimum latency is 2 cycles; each wait cycle adds 1.
- The misaligned path raises `done_o` in cycle 1; read/write never assert.
- Back-to-back throughput: a new `start_i` is accepted in the IDLE cycle following DONE, so at most one access completes per 3 cycles.
- Read/write deassert in the cycle after the completing cycle.

## Structure

- Add `mem_state_t` (IDLE, ACCESS, DONE) to the shared `codes` package.
- Add `OP_LBU` and `OP_LHU` to `opcode_t` in `codes`. Existing `size_t` and `opcode_t` are reused.
- One combinational sub-module, `mem_lane_align`, holds the byteenable generation, store replication and load extraction/extension. It is shared by both directions and unit-testable on its own.

## Test plan

- LW at 0x100, zero wait states, readdata 0xDEADBEEF -> read and address 0x100 in cycle 1; done in cycle 2; load_data 0xDEADBEEF.
- LB at 0x203, readdata 0x80112233 -> byteenable 4'b1000, load_data 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH at 0x302, store_data 0x0000ABCD, waitrequest high for 3 cycles -> address 0x300, byteenable 4'b1100, writedata 0xABCDABCD held stable 4 cycles; done 1 cycle after release.
- LW at 0x102 -> addr_error_o=1 and done in cycle 1; mem_read_o never asserts.
- Reset asserted in ACCESS during a wait state -> mem_read_o, busy_o and done_o drop to 0 asynchronously; the block is in IDLE after release.
- start_i held high through a whole access with opcode SB -> exactly one write observed per 3 cycles; no extra done pulses.
